// File: rtl/otter_mem_arbiter_pkg.sv
// rtl/otter_mem_arbiter_pkg.sv - shared types and helpers for the OTTER memory arbiter
package otter_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } size_t;

    localparam logic [31:0] MEM_ERR_RDATA = 32'h0;

    // Halfwords need bit 0 clear, words need both low bits clear.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == HALF) && addr_lo[0]) || ((size == WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/otter_mem_arbiter_if.sv
// rtl/otter_mem_arbiter_if.sv - fetch, data and memory-port signals of the arbiter
interface otter_mem_arbiter_if;

    logic        i_req;
    logic [31:0] i_addr;
    logic        i_flush;
    logic [31:0] i_rdata;
    logic        i_valid;
    logic        i_err;

    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        d_err;

    logic        m_req;
    logic        m_we;
    logic [1:0]  m_size;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;

    modport slave (
        input  i_req, i_addr, i_flush, d_req, d_we, d_size, d_addr, d_wdata, m_rdata, m_ack,
        output i_rdata, i_valid, i_err, d_rdata, d_valid, d_err,
               m_req, m_we, m_size, m_addr, m_wdata
    );

    modport master (
        output i_req, i_addr, i_flush, d_req, d_we, d_size, d_addr, d_wdata, m_rdata, m_ack,
        input  i_rdata, i_valid, i_err, d_rdata, d_valid, d_err,
               m_req, m_we, m_size, m_addr, m_wdata
    );

endinterface

// File: rtl/otter_mem_arbiter_timer.sv
// rtl/otter_mem_arbiter_timer.sv - loadable/clearable access timer with terminal count
module otter_arb_timer #(
    parameter  int TIMEOUT = 64,
    localparam int W       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    assign o_tc = (r_count == W'(TIMEOUT - 1));

    // Holds at terminal count so an unattended enable cannot wrap.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && !o_tc) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/otter_mem_arbiter.sv
// rtl/otter_mem_arbiter.sv - shares one memory port between instruction fetch and data access
module otter_mem_arbiter
    import otter_mem_pkg::*;
#(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic               CLK,
    input  logic               RST,
    otter_mem_arbiter_if.slave bus
);

    localparam int            SW         = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    arb_state_t    r_state;
    logic [SW-1:0] r_streak;
    logic          r_flush_pend;
    logic          r_m_req;
    logic          r_m_we;
    logic [1:0]    r_m_size;
    logic [31:0]   r_m_addr;
    logic [31:0]   r_m_wdata;
    logic [31:0]   r_i_rdata;
    logic          r_i_valid;
    logic          r_i_err;
    logic [31:0]   r_d_rdata;
    logic          r_d_valid;
    logic          r_d_err;

    logic w_grant_d;
    logic w_grant_i;
    logic w_d_misaligned;
    logic w_busy;
    logic w_tc;
    logic w_done;
    logic w_i_keep;

    assign w_d_misaligned = is_misaligned(bus.d_size, bus.d_addr[1:0]);
    // Data wins unless fetch has already waited through a full streak of data grants.
    assign w_grant_d      = bus.d_req && (!bus.i_req || (r_streak < STREAK_MAX));
    assign w_grant_i      = !w_grant_d && bus.i_req && !bus.i_flush;
    assign w_busy         = (r_state == BUSY_I) || (r_state == BUSY_D);
    assign w_done         = bus.m_ack || w_tc;
    assign w_i_keep       = !(r_flush_pend || bus.i_flush);

    otter_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .CLK        (CLK),
        .RST        (RST),
        .i_clear    (!w_busy),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (w_busy),
        .o_tc       (w_tc)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= IDLE;
            r_streak     <= '0;
            r_flush_pend <= 1'b0;
            r_m_req      <= 1'b0;
            r_m_we       <= 1'b0;
            r_m_size     <= 2'd0;
            r_m_addr     <= 32'h0;
            r_m_wdata    <= 32'h0;
            r_i_rdata    <= 32'h0;
            r_i_valid    <= 1'b0;
            r_i_err      <= 1'b0;
            r_d_rdata    <= 32'h0;
            r_d_valid    <= 1'b0;
            r_d_err      <= 1'b0;
        end else begin
            r_i_valid <= 1'b0;
            r_i_err   <= 1'b0;
            r_d_valid <= 1'b0;
            r_d_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_streak <= bus.i_req ? ((r_streak < STREAK_MAX) ? r_streak + 1'b1 : r_streak)
                                              : '0;
                        if (w_d_misaligned) begin
                            r_d_valid <= 1'b1;
                            r_d_err   <= 1'b1;
                            r_d_rdata <= MEM_ERR_RDATA;
                            r_state   <= RESP;
                        end else begin
                            r_m_req   <= 1'b1;
                            r_m_we    <= bus.d_we;
                            r_m_size  <= bus.d_size;
                            r_m_addr  <= bus.d_addr;
                            r_m_wdata <= bus.d_wdata;
                            r_state   <= BUSY_D;
                        end
                    end else if (w_grant_i) begin
                        r_streak  <= '0;
                        r_m_req   <= 1'b1;
                        r_m_we    <= 1'b0;
                        r_m_size  <= WORD;
                        r_m_addr  <= bus.i_addr;
                        r_m_wdata <= 32'h0;
                        r_state   <= BUSY_I;
                    end
                end
                BUSY_I: begin
                    if (bus.i_flush) begin
                        r_flush_pend <= 1'b1;
                    end
                    // A flushed fetch still finishes on the bus; only its completion is hidden.
                    if (w_done) begin
                        r_m_req   <= 1'b0;
                        r_i_valid <= w_i_keep;
                        r_i_err   <= w_i_keep && !bus.m_ack;
                        r_i_rdata <= bus.m_ack ? bus.m_rdata : MEM_ERR_RDATA;
                        r_state   <= RESP;
                    end
                end
                BUSY_D: begin
                    if (w_done) begin
                        r_m_req   <= 1'b0;
                        r_d_valid <= 1'b1;
                        r_d_err   <= !bus.m_ack;
                        r_d_rdata <= (bus.m_ack && !r_m_we) ? bus.m_rdata : MEM_ERR_RDATA;
                        r_state   <= RESP;
                    end
                end
                RESP: begin
                    r_flush_pend <= 1'b0;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.m_req   = r_m_req;
    assign bus.m_we    = r_m_we;
    assign bus.m_size  = r_m_size;
    assign bus.m_addr  = r_m_addr;
    assign bus.m_wdata = r_m_wdata;
    assign bus.i_rdata = r_i_rdata;
    assign bus.i_valid = r_i_valid;
    assign bus.i_err   = r_i_err;
    assign bus.d_rdata = r_d_rdata;
    assign bus.d_valid = r_d_valid;
    assign bus.d_err   = r_d_err;

    a_d_req_held: assert property (@(posedge CLK) disable iff (RST)
        (r_state == BUSY_D) |-> bus.d_req);
    a_i_req_held: assert property (@(posedge CLK) disable iff (RST)
        ((r_state == BUSY_I) && !r_flush_pend && !bus.i_flush) |-> bus.i_req);

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// tb/tb_otter_mem_arbiter.sv - self-checking bench for otter_mem_arbiter
module tb_otter_mem_arbiter;

    logic CLK;
    logic RST;
    int   n_cmp;
    int   n_err;

    otter_mem_arbiter_if bus();

    otter_mem_arbiter #(.MAX_D_STREAK(4), .TIMEOUT(64)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        n_cmp++;
        if ({bus.i_rdata, bus.i_valid, bus.i_err, bus.d_rdata, bus.d_valid, bus.d_err, bus.m_req,
             bus.m_we, bus.m_size, bus.m_addr, bus.m_wdata} !== '0) begin
            n_err++;
            $display("FAIL reset_in: outputs not zero, m_req=%b i_valid=%b d_valid=%b m_addr=%h",
                     bus.m_req, bus.i_valid, bus.d_valid, bus.m_addr);
        end
        RST = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if ({bus.i_valid, bus.d_valid, bus.m_req} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_after: got valid/valid/req %b%b%b expected 000",
                     bus.i_valid, bus.d_valid, bus.m_req);
        end
    endtask

    task automatic test_fetch();
        @(negedge CLK);
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h100;
        @(negedge CLK);
        n_cmp++;
        if ({bus.m_req, bus.m_we, bus.m_size, bus.m_addr} !== {1'b1, 1'b0, 2'd2, 32'h100}) begin
            n_err++;
            $display("FAIL fetch_grant: got req=%b we=%b size=%0d addr=%h expected 1 0 2 00000100",
                     bus.m_req, bus.m_we, bus.m_size, bus.m_addr);
        end
        bus.m_ack   = 1'b1;
        bus.m_rdata = 32'hDEAD_BEEF;
        @(negedge CLK);
        bus.m_ack = 1'b0;
        n_cmp++;
        if ({bus.i_valid, bus.i_err, bus.i_rdata, bus.m_req} !== {1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0}) begin
            n_err++;
            $display("FAIL fetch_resp: got valid=%b err=%b rdata=%h m_req=%b expected 1 0 deadbeef 0",
                     bus.i_valid, bus.i_err, bus.i_rdata, bus.m_req);
        end
        bus.i_req = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (bus.i_valid !== 1'b0) begin
            n_err++;
            $display("FAIL fetch_pulse: i_valid=%b expected 0", bus.i_valid);
        end
    endtask

    task automatic test_misaligned();
        @(negedge CLK);
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_size  = 2'd1;
        bus.d_addr  = 32'h203;
        bus.d_wdata = 32'hCAFE_F00D;
        @(negedge CLK);
        n_cmp++;
        if ({bus.m_req, bus.d_valid, bus.d_err, bus.d_rdata} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
            n_err++;
            $display("FAIL misaligned_resp: got m_req=%b valid=%b err=%b rdata=%h expected 0 1 1 0",
                     bus.m_req, bus.d_valid, bus.d_err, bus.d_rdata);
        end
        bus.d_req = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if ({bus.m_req, bus.d_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL misaligned_after: got m_req=%b d_valid=%b expected 00", bus.m_req, bus.d_valid);
        end
    endtask

    task automatic test_streak();
        int  exp_seq [6] = '{1, 1, 1, 1, 0, 1};
        int  got_seq [6];
        int  n_gr;
        bit  prev;
        n_gr = 0;
        prev = 1'b0;
        @(negedge CLK);
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_size = 2'd2;
        bus.d_addr = 32'h8000_0200;
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h300;
        for (int k = 0; k < 200 && n_gr < 6; k++) begin
            @(negedge CLK);
            bus.m_ack = 1'b0;
            if (bus.m_req && !prev) begin
                got_seq[n_gr] = int'(bus.m_addr[31]);
                n_gr++;
                bus.m_ack   = 1'b1;
                bus.m_rdata = mem_f(bus.m_addr);
            end
            prev = bus.m_req;
        end
        @(negedge CLK);
        bus.m_ack = 1'b0;
        bus.d_req = 1'b0;
        bus.i_req = 1'b0;
        n_cmp++;
        if (n_gr != 6) begin
            n_err++;
            $display("FAIL streak_count: got %0d grants expected 6", n_gr);
        end
        for (int k = 0; k < 6; k++) begin
            if (k < n_gr) begin
                n_cmp++;
                if (got_seq[k] != exp_seq[k]) begin
                    n_err++;
                    $display("FAIL streak_grant%0d: got %s expected %s", k,
                             got_seq[k] == 1 ? "D" : "I", exp_seq[k] == 1 ? "D" : "I");
                end
            end
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_timeout();
        int cnt;
        bit got;
        cnt = 0;
        got = 1'b0;
        @(negedge CLK);
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h400;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            if (bus.i_valid) begin
                got = 1'b1;
                break;
            end
            if (bus.m_req) cnt++;
        end
        n_cmp++;
        if (cnt != 64) begin
            n_err++;
            $display("FAIL timeout_len: m_req high %0d cycles expected 64", cnt);
        end
        n_cmp++;
        if (!got || {bus.i_err, bus.i_rdata, bus.m_req} !== {1'b1, 32'h0, 1'b0}) begin
            n_err++;
            $display("FAIL timeout_resp: got valid=%b err=%b rdata=%h m_req=%b expected 1 1 0 0",
                     got, bus.i_err, bus.i_rdata, bus.m_req);
        end
        bus.i_req = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_flush();
        bit seen_valid;
        bit regrant;
        seen_valid = 1'b0;
        regrant    = 1'b0;
        @(negedge CLK);
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h500;
        for (int c = 1; c <= 6; c++) begin
            @(negedge CLK);
            bus.m_ack = 1'b0;
            if (bus.i_valid) seen_valid = 1'b1;
            if (c == 1) begin
                n_cmp++;
                if ({bus.m_req, bus.m_addr} !== {1'b1, 32'h500}) begin
                    n_err++;
                    $display("FAIL flush_grant: got m_req=%b addr=%h expected 1 00000500", bus.m_req, bus.m_addr);
                end
            end
            if (c == 2) bus.i_flush = 1'b1;
            if (c == 3) begin
                bus.i_flush = 1'b0;
                bus.i_addr  = 32'h600;
            end
            if (c == 5) begin
                bus.m_ack   = 1'b1;
                bus.m_rdata = 32'h1111_1111;
            end
            if (c == 6) begin
                n_cmp++;
                if (bus.m_req !== 1'b0) begin
                    n_err++;
                    $display("FAIL flush_mreq_drop: m_req=%b expected 0", bus.m_req);
                end
            end
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (bus.i_valid) seen_valid = 1'b1;
            if (bus.m_req) begin
                regrant = 1'b1;
                n_cmp++;
                if (bus.m_addr !== 32'h600) begin
                    n_err++;
                    $display("FAIL flush_regrant_addr: got %h expected 00000600", bus.m_addr);
                end
                bus.m_ack   = 1'b1;
                bus.m_rdata = 32'h2222_2222;
                break;
            end
        end
        n_cmp++;
        if (seen_valid || !regrant) begin
            n_err++;
            $display("FAIL flush_suppress: stale i_valid=%b regrant=%b expected 0 1", seen_valid, regrant);
        end
        @(negedge CLK);
        bus.m_ack = 1'b0;
        n_cmp++;
        if ({bus.i_valid, bus.i_err, bus.i_rdata} !== {1'b1, 1'b0, 32'h2222_2222}) begin
            n_err++;
            $display("FAIL flush_refetch: got valid=%b err=%b rdata=%h expected 1 0 22222222",
                     bus.i_valid, bus.i_err, bus.i_rdata);
        end
        bus.i_req = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_random();
        int          streak;
        int          ack_wait;
        int          i_age;
        int          d_age;
        int          done;
        bit          i_pend;
        bit          d_pend;
        bit          i_gr;
        bit          d_gr;
        bit          prev_mreq;
        bit          exp_d;
        bit          exp_i;
        bit          got_d;
        bit          mis;
        logic        cur_i;
        logic        cur_d;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] dw;
        logic [31:0] exp_rd;
        logic [1:0]  ds;
        logic        dwe;
        streak = 0; ack_wait = -1; i_age = 0; d_age = 0; done = 0;
        i_pend = 0; d_pend = 0; i_gr = 0; d_gr = 0; prev_mreq = 0;
        ia = 0; da = 0; dw = 0; ds = 0; dwe = 0;
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge CLK);
            cur_i       = bus.i_req;
            cur_d       = bus.d_req;
            bus.m_ack   = 1'b0;
            bus.m_rdata = $urandom;
            exp_d = cur_d && (!cur_i || streak < 4);
            exp_i = !exp_d && cur_i;
            mis   = (ds == 2'd1 && da[0]) || (ds == 2'd2 && da[1:0] != 2'b00);
            if (bus.m_req && !prev_mreq) begin
                got_d = bus.m_addr[31];
                n_cmp++;
                if (got_d ? !exp_d : !exp_i) begin
                    n_err++;
                    $display("FAIL rnd_grant_who: got %s expected %s (i=%b d=%b streak=%0d)",
                             got_d ? "D" : "I", exp_d ? "D" : (exp_i ? "I" : "none"), cur_i, cur_d, streak);
                end
                n_cmp++;
                if (got_d) begin
                    if (mis || {bus.m_we, bus.m_size, bus.m_addr, bus.m_wdata} !== {dwe, ds, da, dw}) begin
                        n_err++;
                        $display("FAIL rnd_grant_d: got we=%b size=%0d addr=%h wdata=%h expected %b %0d %h %h mis=%b",
                                 bus.m_we, bus.m_size, bus.m_addr, bus.m_wdata, dwe, ds, da, dw, mis);
                    end
                    streak = cur_i ? ((streak < 4) ? streak + 1 : 4) : 0;
                    d_gr   = 1'b1;
                end else begin
                    if ({bus.m_we, bus.m_size, bus.m_addr, bus.m_wdata} !== {1'b0, 2'd2, ia, 32'h0}) begin
                        n_err++;
                        $display("FAIL rnd_grant_i: got we=%b size=%0d addr=%h wdata=%h expected 0 2 %h 0",
                                 bus.m_we, bus.m_size, bus.m_addr, bus.m_wdata, ia);
                    end
                    streak = 0;
                    i_gr   = 1'b1;
                end
                ack_wait = $urandom_range(0, 3);
            end
            if (bus.d_valid && !d_gr) begin
                n_cmp++;
                if (!exp_d || !mis || {bus.d_err, bus.d_rdata} !== {1'b1, 32'h0}) begin
                    n_err++;
                    $display("FAIL rnd_misaligned: got err=%b rdata=%h expected 1 0 (exp_d=%b mis=%b)",
                             bus.d_err, bus.d_rdata, exp_d, mis);
                end
                streak = cur_i ? ((streak < 4) ? streak + 1 : 4) : 0;
                d_pend = 1'b0; bus.d_req = 1'b0; done++;
            end else if (bus.d_valid) begin
                exp_rd = dwe ? 32'h0 : mem_f(da);
                n_cmp++;
                if ({bus.d_err, bus.d_rdata} !== {1'b0, exp_rd}) begin
                    n_err++;
                    $display("FAIL rnd_d_resp: got err=%b rdata=%h expected 0 %h", bus.d_err, bus.d_rdata, exp_rd);
                end
                d_gr = 1'b0; d_pend = 1'b0; bus.d_req = 1'b0; done++;
            end
            if (bus.i_valid) begin
                n_cmp++;
                if (!i_gr || {bus.i_err, bus.i_rdata} !== {1'b0, mem_f(ia)}) begin
                    n_err++;
                    $display("FAIL rnd_i_resp: got err=%b rdata=%h expected 0 %h (granted=%b)",
                             bus.i_err, bus.i_rdata, mem_f(ia), i_gr);
                end
                i_gr = 1'b0; i_pend = 1'b0; bus.i_req = 1'b0; done++;
            end
            if (ack_wait == 0) begin
                bus.m_ack   = 1'b1;
                bus.m_rdata = mem_f(bus.m_addr);
                ack_wait    = -1;
            end else if (ack_wait > 0) begin
                ack_wait--;
            end
            if (i_pend) i_age++;
            if (d_pend) d_age++;
            if (i_age > 150 || d_age > 150) begin
                n_cmp++;
                n_err++;
                $display("FAIL rnd_wait_bound: i_age=%0d d_age=%0d limit 150", i_age, d_age);
                break;
            end
            if (cyc < 3000) begin
                if (!i_pend && $urandom_range(0, 3) == 0) begin
                    ia = {16'h0, 16'($urandom) & 16'hFFFC};
                    bus.i_addr = ia; bus.i_req = 1'b1; i_pend = 1'b1; i_age = 0;
                end
                if (!d_pend && $urandom_range(0, 2) == 0) begin
                    da = {1'b1, 31'($urandom)};
                    if ($urandom_range(0, 1) == 1) da[1:0] = 2'b00;
                    ds  = 2'($urandom_range(0, 2));
                    dwe = 1'($urandom_range(0, 1));
                    dw  = $urandom;
                    bus.d_addr = da; bus.d_size = ds; bus.d_we = dwe; bus.d_wdata = dw;
                    bus.d_req = 1'b1; d_pend = 1'b1; d_age = 0;
                end
            end else if (!i_pend && !d_pend && ack_wait < 0) begin
                break;
            end
            prev_mreq = bus.m_req;
        end
        bus.m_ack = 1'b0;
        n_cmp++;
        if (done < 100) begin
            n_err++;
            $display("FAIL rnd_throughput: %0d completions expected at least 100", done);
        end
        @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        bit bad;
        bad = 1'b0;
        @(negedge CLK);
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_size = 2'd2;
        bus.d_addr = 32'h8000_0700;
        @(negedge CLK);
        n_cmp++;
        if (bus.m_req !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_busy: m_req=%b expected 1", bus.m_req);
        end
        #2 RST = 1'b1;
        #1;
        n_cmp++;
        if ({bus.i_rdata, bus.i_valid, bus.i_err, bus.d_rdata, bus.d_valid, bus.d_err, bus.m_req,
             bus.m_we, bus.m_size, bus.m_addr, bus.m_wdata} !== '0) begin
            n_err++;
            $display("FAIL rstmid_async: m_req=%b m_addr=%h d_rdata=%h expected all 0",
                     bus.m_req, bus.m_addr, bus.d_rdata);
        end
        @(negedge CLK);
        bus.d_req = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (bus.d_valid || bus.m_req) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL rstmid_quiet: d_valid or m_req seen after reset release, expected none");
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        RST         = 1'b1;
        bus.i_req   = 1'b0;
        bus.i_addr  = 32'h0;
        bus.i_flush = 1'b0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_size  = 2'd0;
        bus.d_addr  = 32'h0;
        bus.d_wdata = 32'h0;
        bus.m_rdata = 32'h0;
        bus.m_ack   = 1'b0;
        test_reset();
        test_fetch();
        test_misaligned();
        test_streak();
        test_timeout();
        test_flush();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/otter_mem_arbiter.md
Name: otter_mem_arbiter

Overview:
- Shares one unified memory port between the pipeline's instruction-fetch (I) and data-access (D) requesters in OTTER_MCU.
- Serialises accesses, supports a variable-latency memory ack, and applies a starvation guard.
- Enforces an access timeout and drops fetches made stale by a flush.
- Sits between the IF/MEM pipeline stages and the memory/bus interface; the hazard unit stalls on req-without-valid.

Parameters:
MAX_D_STREAK, 4, consecutive D grants allowed while I waits before I is forced
TIMEOUT, 64, cycles to wait for m_ack before aborting with error

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
i_req  in  1  fetch request, held with i_addr stable until i_valid
i_addr  in  32  fetch address (word aligned)
i_flush  in  1  cancel pending/in-flight fetch
i_rdata  out  32  fetched instruction
i_valid  out  1  one-cycle fetch completion pulse
d_req  in  1  data request, held with d_* stable until d_valid
d_we  in  1  1 = store
d_size  in  2  0 byte, 1 half, 2 word
d_addr  in  32  data address
d_wdata  in  32  store data
d_rdata  out  32  load data (raw word; sign/extend done in MEM stage)
d_valid  out  1  one-cycle data completion pulse
d_err  out  1  error qualifier, valid with d_valid
i_err  out  1  error qualifier, valid with i_valid
m_req  out  1  memory request, held until m_ack
m_we, m_size, m_addr, m_wdata  out  1/2/32/32  registered copies of granted request
m_rdata  in  32  memory read data, valid with m_ack
m_ack  in  1  memory completion, one cycle

Behaviour:
- Reset (async): state IDLE; all outputs 0; streak=0; timer=0; flush_pend=0.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE arbitration (cycle N):
  - If d_req and (!i_req or streak<MAX_D_STREAK): grant D.
  - Else if i_req and !i_flush: grant I.
  - On grant: latch m_addr/m_we/m_size/m_wdata (I grant: m_we=0, m_size=2, m_wdata=0); m_req=1 from N+1.
- Streak counter:
  - D grant while i_req high: streak++ (saturating).
  - Any I grant, or D grant with i_req low: streak=0.
- Misaligned D (size1 & addr[0]; size2 & addr[1:0]!=0):
  - No memory access; straight to RESP.
  - d_valid=1, d_err=1, d_rdata=0 at N+1.
- BUSY_x:
  - m_req held high, m_* stable; timer++ each cycle.
  - On m_ack: capture m_rdata, m_req=0, go RESP.
  - timer reaching TIMEOUT-1 without ack: m_req=0, x_err=1, rdata=0, go RESP.
- RESP (one cycle): pulse x_valid with captured data/err; go IDLE; timer=0.
  - Minimum latency: request at N, ack at N+1, valid at N+2, next grant at N+3.
- Flush:
  - i_flush in IDLE suppresses an I grant that cycle.
  - i_flush during BUSY_I sets flush_pend; the memory transaction still completes, but i_valid is suppressed.
  - flush_pend clears on RESP.
- d_req/i_req dropping mid-transaction is illegal (assertion); memory access still completes.
- Simultaneous m_ack and timeout terminal count: ack wins, no error.
- Stores return d_valid with d_rdata=0.
- Reset mid-transaction: immediate return to IDLE, m_req drops asynchronously, no valid pulse.

Decomposition:
- otter_mem_pkg: arb_state_t enum; size_t (BYTE/HALF/WORD); MEM_ERR_RDATA=32'h0.
- Sub-module otter_arb_timer: loadable/clearable counter with terminal-count output, parameterised by TIMEOUT; reused by later bus bridges.

Test Plan:
- i_req=1, addr 0x100; m_ack 1 cycle after m_req -> m_addr=0x100, m_size=2, i_valid at N+2 with i_rdata=m_rdata, i_err=0.
- i_req and d_req both held high, m_ack immediate -> grants D,D,D,D,I (MAX_D_STREAK=4), streak resets, next grant D.
- d_req store, size=1, addr 0x203 -> no m_req, d_valid=1, d_err=1 at N+1.
- Fetch granted, m_ack never asserted -> m_req high exactly 64 cycles, then i_valid=1, i_err=1, i_rdata=0.
- i_flush pulsed 2 cycles into BUSY_I, ack at cycle 5 -> no i_valid; next i_req granted normally.
- RST asserted mid BUSY_D -> m_req=0 within same cycle (async); all outputs 0; no d_valid after release.
